// File: rtl/FHE_ALU_PKG.sv
// -----------------------------------------------------------------------------
// FHE_ALU_PKG
// Shared AXI protocol encodings used by the FHE ALU bus masters.
//   AXI_BURST_*  : AWBURST / ARBURST encodings (FIXED, INCR, WRAP)
//   AXI_RESP_*   : BRESP / RRESP encodings (OKAY, SLVERR)
// -----------------------------------------------------------------------------
package FHE_ALU_PKG;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage : FHE_ALU_PKG

// File: rtl/axi_burst_wr_master.sv
// -----------------------------------------------------------------------------
// axi_burst_wr_master
// Single-outstanding AXI4 write burst master. A command (start address, LEN)
// is accepted in IDLE, the AW request is issued, LEN+1 beats are streamed from
// a valid/ready source through a one-entry W output register, and the B
// response is reported as a one-cycle done pulse with an error flag.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      : burst command handshake
//   cmd_addr, cmd_len        : burst start byte address, beats minus one
//   s_data/s_valid/s_ready   : source beat stream
//   done, err                : burst-complete pulse, BRESP != OKAY (with done)
//   M_AXI_AW*                : AXI write address channel
//   M_AXI_W*                 : AXI write data channel
//   M_AXI_B*                 : AXI write response channel
// -----------------------------------------------------------------------------
module axi_burst_wr_master
    import FHE_ALU_PKG::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 1024,
    parameter int C_M_AXI_ADDR_WIDTH = 11
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                      cmd_len,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_data,
    input  logic                            s_valid,
    output logic                            s_ready,

    output logic                            done,
    output logic                            err,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    localparam int         STRB_W   = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [2:0] AWSIZE_C = 3'($clog2(STRB_W));

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]                    state_q,    state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q,   awaddr_d;
    logic [7:0]                    awlen_q,    awlen_d;
    logic                          awvalid_q,  awvalid_d;
    logic                          wvalid_q,   wvalid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [7:0]                    beat_cnt_q, beat_cnt_d;   // W handshakes done
    logic [8:0]                    load_cnt_q, load_cnt_d;   // beats taken from source
    logic                          done_q,     done_d;
    logic                          err_q,      err_d;

    logic s_fire;
    logic w_fire;
    logic w_last;

    // The output register may be refilled in the same cycle it drains; the
    // 9-bit load count stops the source once all LEN+1 beats are taken.
    assign s_ready = (state_q == ST_DATA)
                   && (!wvalid_q || M_AXI_WREADY)
                   && (load_cnt_q <= {1'b0, awlen_q});
    assign s_fire  = s_valid && s_ready;
    assign w_fire  = wvalid_q && M_AXI_WREADY;
    // WLAST follows the handshake count, so it is stable while WREADY is low.
    assign w_last  = wvalid_q && (beat_cnt_q == awlen_q);

    assign cmd_ready     = (state_q == ST_IDLE);
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWSIZE  = AWSIZE_C;
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_last;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == ST_RESP);
    assign done          = done_q;
    assign err           = err_q;

    always_comb begin
        // NOTE: every next-state value starts from a hold/default assignment
        // so no path through the case leaves it unassigned (no latches).
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        wdata_d    = wdata_q;
        beat_cnt_d = beat_cnt_q;
        load_cnt_d = load_cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    awaddr_d   = cmd_addr;
                    awlen_d    = cmd_len;
                    beat_cnt_d = '0;
                    load_cnt_d = '0;
                    awvalid_d  = 1'b1;
                    state_d    = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (s_fire) begin
                    wdata_d    = s_data;
                    wvalid_d   = 1'b1;
                    load_cnt_d = load_cnt_q + 9'd1;
                end else if (w_fire) begin
                    wvalid_d   = 1'b0;
                end
                if (w_fire) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (w_last) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (M_AXI_BVALID) begin
                    done_d  = 1'b1;
                    err_d   = (M_AXI_BRESP != AXI_RESP_OKAY);
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q    <= ST_IDLE;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            beat_cnt_q <= '0;
            load_cnt_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            beat_cnt_q <= beat_cnt_d;
            load_cnt_q <= load_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the wide data register is not reset; it is only observed while
    // WVALID is high, and WVALID is always reset.
    always_ff @(posedge M_AXI_ACLK) begin
        wdata_q <= wdata_d;
    end

endmodule : axi_burst_wr_master

// File: doc/axi_burst_wr_master.md
AXI_BURST_WR_MASTER -- requirements
Module: axi_burst_wr_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 1024, AXI write data width in bits.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 11, AXI byte address width.
REQ-003 SHALL have port M_AXI_ACLK, input, 1, single clock; one clock, all logic rising-edge.
REQ-004 SHALL have port M_AXI_ARESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, burst command valid.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when both high.
REQ-007 SHALL have port cmd_addr, input, C_M_AXI_ADDR_WIDTH, burst start byte address.
REQ-008 SHALL have port cmd_len, input, 8, beats minus one (AXI LEN encoding).
REQ-009 SHALL have port s_data, input, C_M_AXI_DATA_WIDTH, source beat data.
REQ-010 SHALL have port s_valid, input, 1, source beat valid.
REQ-011 SHALL have port s_ready, output, 1, source beat accepted when both high.
REQ-012 SHALL have port done, output, 1, one-cycle burst-complete pulse.
REQ-013 SHALL have port err, output, 1, valid with done; high if BRESP not OKAY.
REQ-014 SHALL have ports M_AXI_AWADDR (output, C_M_AXI_ADDR_WIDTH), M_AXI_AWLEN (output, 8), M_AXI_AWSIZE (output, 3), M_AXI_AWBURST (output, 2), M_AXI_AWVALID (output, 1), M_AXI_AWREADY (input, 1): AW channel.
REQ-015 SHALL have ports M_AXI_WDATA (output, C_M_AXI_DATA_WIDTH), M_AXI_WSTRB (output, C_M_AXI_DATA_WIDTH/8), M_AXI_WLAST (output, 1), M_AXI_WVALID (output, 1), M_AXI_WREADY (input, 1): W channel.
REQ-016 SHALL have ports M_AXI_BRESP (input, 2), M_AXI_BVALID (input, 1), M_AXI_BREADY (output, 1): B channel.

Function
REQ-017 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
REQ-018 SHALL, in IDLE: cmd_ready=1; on cmd_valid, latch cmd_addr/cmd_len into AWADDR/AWLEN, clear beat counter, go ADDR.
REQ-019 SHALL, in ADDR: AWVALID=1 registered; on AWREADY, drop AWVALID next cycle and go DATA; no W beat before AW handshake completes.
REQ-020 SHALL drive AWSIZE=clog2(C_M_AXI_DATA_WIDTH/8), AWBURST=INCR (2'b01), WSTRB all ones, constant.
REQ-021 SHALL hold W beat in a one-entry output register: s_ready=1 in DATA when register empty or (WVALID and WREADY), and fewer than AWLEN+1 beats loaded.
REQ-022 SHALL assert WLAST with the beat whose count equals AWLEN; count 8-bit, increments on each W handshake.
REQ-023 SHALL tolerate WREADY low for any number of cycles: WDATA/WVALID/WLAST stable until handshake.
REQ-024 SHALL go RESP on the WLAST handshake; in RESP BREADY=1, otherwise 0.
REQ-025 SHALL, on BVALID in RESP, pulse done for one cycle, set err=(BRESP!=2'b00), return IDLE.
REQ-026 SHALL handle cmd_len=0 as a single beat with WLAST on the first beat.
REQ-027 SHALL ignore cmd_valid outside IDLE (cmd_ready=0); s_valid outside DATA is not consumed.
REQ-028 SHALL accept a new command on the cycle after done (minimum one-cycle IDLE).

Reset
REQ-029 SHALL, on M_AXI_ARESET high at any time including mid-burst, asynchronously force IDLE, AWVALID=0, WVALID=0, WLAST=0, BREADY=0, done=0, err=0, AWADDR=0, AWLEN=0, counter=0, W register empty; cmd_ready=1 after release.

Structure
REQ-030 SHALL take burst encodings (FIXED/INCR/WRAP) and OKAY/SLVERR response constants from FHE_ALU_PKG; FSM state enum local.
REQ-031 SHALL be one flat module; no sub-module.

Verification
REQ-032 cmd addr=0x000 len=3, stream 4 beats, WREADY/AWREADY always high -> 4 W handshakes, WLAST on beat 4 only, BRESP=00 -> done=1 err=0.
REQ-033 len=0 -> exactly one beat with WLAST=1, AWLEN=0.
REQ-034 len=7, WREADY toggling 1/0 each cycle, s_valid gaps -> WDATA order preserved, 8 beats, no drops/duplicates.
REQ-035 BRESP=2'b10 -> done=1 err=1, next cmd accepted following cycle.
REQ-036 reset asserted at beat 2 of len=5 -> all valids low immediately, IDLE; subsequent len=1 burst completes normally.
REQ-037 cmd_valid held high during DATA -> second command accepted only after done.
